// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchronised rx, mid-bit start validation,
// LSB-first sampling, one-deep holding register with framing/overrun flags.
module uart_rx #(
  parameter int unsigned DIVISOR = 416
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       re,
  output logic [7:0] rdata,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] CNT_HALF = 16'(DIVISOR / 2);
  localparam logic [15:0] CNT_FULL = 16'(DIVISOR);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state_q;
  logic        sync_q, rxs_q, rxs_dly_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        commit_q, stop_bit_q;
  logic [7:0]  rdata_q;
  logic        valid_q, frame_err_q, overrun_q, busy_q;
  logic        rx_fall, cnt_half_hit, cnt_full_hit;

  always_comb begin
    rx_fall      = rxs_dly_q & ~rxs_q;
    cnt_half_hit = (cnt_q == CNT_HALF);
    cnt_full_hit = (cnt_q == CNT_FULL);
    cnt_d        = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 1'b1;
      rxs_q     <= 1'b1;
      rxs_dly_q <= 1'b1;
    end else begin
      sync_q    <= rx;
      rxs_q     <= sync_q;
      rxs_dly_q <= rxs_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      commit_q    <= 1'b0;
      stop_bit_q  <= 1'b0;
      rdata_q     <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_fall) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_half_hit) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DATA: begin
          if (cnt_full_hit) begin
            shift_q   <= {rxs_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            cnt_q     <= '0;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        STOP: begin
          if (cnt_full_hit) begin
            stop_bit_q <= rxs_q;
            commit_q   <= 1'b1;
            cnt_q      <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= BREAK;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        BREAK: begin
          // a held-low line must return high before a new start is accepted
          if (rxs_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase

      if (commit_q) begin
        if (!valid_q || re) begin
          rdata_q     <= shift_q;
          valid_q     <= 1'b1;
          frame_err_q <= ~stop_bit_q;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (re && valid_q) begin
        valid_q     <= 1'b0;
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
    end
  end

  assign rdata     = rdata_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model of the holding register checked every
// cycle, plus directed literal checks for each scenario.
module tb_uart_rx;

  localparam int unsigned D15   = 15;
  localparam int unsigned D416  = 416;
  localparam int          LAT15 = D15 / 2 + 9 * (D15 + 1) + 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx15, re15, rx416, re416;
  logic [7:0] rdata15, rdata416;
  logic       valid15, ferr15, ovr15, busy15;
  logic       valid416, ferr416, ovr416, busy416;

  uart_rx #(.DIVISOR(D15)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx15), .re(re15),
    .rdata(rdata15), .valid(valid15), .frame_err(ferr15),
    .overrun(ovr15), .busy(busy15)
  );

  uart_rx #(.DIVISOR(D416)) dut416 (
    .clk(clk), .rst_n(rst_n), .rx(rx416), .re(re416),
    .rdata(rdata416), .valid(valid416), .frame_err(ferr416),
    .overrun(ovr416), .busy(busy416)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [7:0] data;
    logic       stop;
  } frame_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         edge_idx = 0;
  frame_t     exp_q[$];
  logic [7:0] m_rdata = '0;
  logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  int         rise15 = -1, rise416 = -1;
  logic       v15_prev = 1'b0, v416_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_idx);
    end
  endtask

  // Holding-register model: a tracked frame lands LAT15 edges after its start edge.
  always @(posedge clk) begin
    #1;
    edge_idx++;
    if (!rst_n) begin
      m_rdata = '0;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      exp_q.delete();
    end else if (exp_q.size() > 0 && exp_q[0].edge_no == edge_idx) begin
      if (!m_valid || re15) begin
        m_rdata = exp_q[0].data;
        m_valid = 1'b1;
        m_ferr  = ~exp_q[0].stop;
      end else begin
        m_ovr = 1'b1;
      end
      void'(exp_q.pop_front());
    end else if (re15 && m_valid) begin
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
    end
    chk("model_rdata",   32'(rdata15), 32'(m_rdata));
    chk("model_valid",   32'(valid15), 32'(m_valid));
    chk("model_ferr",    32'(ferr15),  32'(m_ferr));
    chk("model_overrun", 32'(ovr15),   32'(m_ovr));
    if (valid15 && !v15_prev && rise15 < 0) rise15 = edge_idx;
    if (valid416 && !v416_prev && rise416 < 0) rise416 = edge_idx;
    v15_prev  = valid15;
    v416_prev = valid416;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int w, input logic v);
    if (w == 1) rx416 = v;
    else        rx15  = v;
  endtask

  task automatic tx_frame(input int w, input logic [7:0] b, input logic stopb,
                          input bit track, output int start_edge);
    int     per;
    frame_t f;
    per = (w == 1) ? int'(D416) + 1 : int'(D15) + 1;
    start_edge = edge_idx + 1;
    if (track) begin
      f.edge_no = start_edge + LAT15;
      f.data    = b;
      f.stop    = stopb;
      exp_q.push_back(f);
    end
    set_rx(w, 1'b0);
    wait_neg(per);
    for (int i = 0; i < 8; i++) begin
      set_rx(w, b[i]);
      wait_neg(per);
    end
    set_rx(w, stopb);
    wait_neg(per);
  endtask

  task automatic pulse_re15();
    re15 = 1'b1;
    wait_neg(1);
    re15 = 1'b0;
  endtask

  int         s1, s3, s4a, s4b, s5a, s5b, s6, s416;
  int         c2, guard;
  logic [7:0] b81;

  initial begin
    rst_n = 1'b0;
    rx15  = 1'b1;
    rx416 = 1'b1;
    re15  = 1'b0;
    re416 = 1'b0;
    wait_neg(3);
    chk("reset_rdata",  32'(rdata15), 32'h0);
    chk("reset_valid",  32'(valid15), 32'h0);
    chk("reset_ferr",   32'(ferr15),  32'h0);
    chk("reset_ovr",    32'(ovr15),   32'h0);
    chk("reset_busy",   32'(busy15),  32'h0);
    chk("reset_busy416", 32'(busy416), 32'h0);
    rst_n = 1'b1;
    wait_neg(3);

    // 1: plain byte, latency, read
    tx_frame(0, 8'hA5, 1'b1, 1'b1, s1);
    chk("t1_rdata",   32'(rdata15), 32'hA5);
    chk("t1_valid",   32'(valid15), 32'h1);
    chk("t1_ferr",    32'(ferr15),  32'h0);
    chk("t1_ovr",     32'(ovr15),   32'h0);
    chk("t1_busy",    32'(busy15),  32'h0);
    chk("t1_latency", 32'(rise15 - s1), 32'd155);
    pulse_re15();
    chk("t1_read_valid", 32'(valid15), 32'h0);

    // 2: short glitch
    set_rx(0, 1'b0);
    wait_neg(4);
    set_rx(0, 1'b1);
    chk("t2_busy_seen", 32'(busy15), 32'h1);
    wait_neg(11);
    chk("t2_busy_clear", 32'(busy15), 32'h0);
    chk("t2_no_valid",   32'(valid15), 32'h0);

    // 3: framing error with held break, then recovery
    tx_frame(0, 8'h00, 1'b0, 1'b1, s3);
    wait_neg(40);
    chk("t3_busy_break", 32'(busy15),  32'h1);
    chk("t3_valid",      32'(valid15), 32'h1);
    chk("t3_rdata",      32'(rdata15), 32'h00);
    chk("t3_ferr",       32'(ferr15),  32'h1);
    set_rx(0, 1'b1);
    wait_neg(5);
    chk("t3_busy_end", 32'(busy15), 32'h0);
    pulse_re15();
    tx_frame(0, 8'h3C, 1'b1, 1'b1, s3);
    chk("t3_next_rdata", 32'(rdata15), 32'h3C);
    chk("t3_next_valid", 32'(valid15), 32'h1);
    chk("t3_next_ferr",  32'(ferr15),  32'h0);
    pulse_re15();

    // 4: overrun
    tx_frame(0, 8'h11, 1'b1, 1'b1, s4a);
    tx_frame(0, 8'h22, 1'b1, 1'b1, s4b);
    chk("t4_rdata", 32'(rdata15), 32'h11);
    chk("t4_valid", 32'(valid15), 32'h1);
    chk("t4_ovr",   32'(ovr15),   32'h1);
    pulse_re15();
    chk("t4_read_valid", 32'(valid15), 32'h0);
    chk("t4_read_ovr",   32'(ovr15),   32'h0);

    // 5: read in the exact commit cycle of the second byte
    c2 = edge_idx + 1 + 10 * (int'(D15) + 1) + LAT15;
    fork
      begin
        tx_frame(0, 8'h55, 1'b1, 1'b1, s5a);
        tx_frame(0, 8'h66, 1'b1, 1'b1, s5b);
      end
      begin
        guard = 0;
        while (edge_idx < c2 - 1 && guard < 2000) begin
          wait_neg(1);
          guard++;
        end
        if (guard >= 2000) begin
          n_checks++;
          n_fail++;
          $display("FAIL t5_re_window: timed out at edge %0d, needed %0d", edge_idx, c2 - 1);
        end
        pulse_re15();
      end
    join
    chk("t5_rdata", 32'(rdata15), 32'h66);
    chk("t5_valid", 32'(valid15), 32'h1);
    chk("t5_ovr",   32'(ovr15),   32'h0);

    // 6: async reset mid-DATA, then recovery
    b81 = 8'h81;
    set_rx(0, 1'b0);
    wait_neg(16);
    for (int i = 0; i < 3; i++) begin
      set_rx(0, b81[i]);
      wait_neg(16);
    end
    wait_neg(5);
    chk("t6_busy_mid", 32'(busy15), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rdata", 32'(rdata15), 32'h0);
    chk("t6_rst_valid", 32'(valid15), 32'h0);
    chk("t6_rst_ferr",  32'(ferr15),  32'h0);
    chk("t6_rst_ovr",   32'(ovr15),   32'h0);
    chk("t6_rst_busy",  32'(busy15),  32'h0);
    set_rx(0, 1'b1);
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(3);
    tx_frame(0, 8'h7E, 1'b1, 1'b1, s6);
    chk("t6_rdata", 32'(rdata15), 32'h7E);
    chk("t6_valid", 32'(valid15), 32'h1);
    chk("t6_ferr",  32'(ferr15),  32'h0);
    pulse_re15();

    // 1 again at DIVISOR=416
    tx_frame(1, 8'hA5, 1'b1, 1'b0, s416);
    chk("d416_rdata",   32'(rdata416), 32'hA5);
    chk("d416_valid",   32'(valid416), 32'h1);
    chk("d416_ferr",    32'(ferr416),  32'h0);
    chk("d416_ovr",     32'(ovr416),   32'h0);
    chk("d416_busy",    32'(busy416),  32'h0);
    chk("d416_latency", 32'(rise416 - s416), 32'd3965);
    re416 = 1'b1;
    wait_neg(1);
    re416 = 1'b0;
    chk("d416_read_valid", 32'(valid416), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_idx);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
